// File: rtl/reg_dump_reader.sv
// Sequential readback of a 1-cycle-latency register bank.
// Each word is streamed out with its index over valid/ready.
module reg_dump_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] nxt;

  assign nxt = idx + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (abort && state != S_IDLE) begin
      // abort beats any handshake; captured word is kept
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state   <= S_READ;
            idx     <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        S_READ: begin
          rd_en <= 1'b0;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_data  <= rd_data;
          out_index <= idx;
          out_valid <= 1'b1;
          state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              idx     <= nxt;
              rd_addr <= nxt;
              rd_en   <= 1'b1;
              state   <= S_READ;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader.
// Main instance dumps 32 regs; side instances cover 1 and 20.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, rd_en, out_valid;
  logic [4:0]  rd_addr, out_index;
  logic [31:0] rd_data = '0;
  logic [31:0] out_data;

  logic        s1_start = 1'b0, s20_start = 1'b0;
  logic        s1_busy, s1_done, s1_rd_en, s1_valid;
  logic        s20_busy, s20_done, s20_rd_en, s20_valid;
  logic [4:0]  s1_addr, s1_idx, s20_addr, s20_idx;
  logic [31:0] s1_rdata = '0, s20_rdata = '0;
  logic [31:0] s1_data, s20_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  reg_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  reg_dump_reader #(.NUM_REGS(1)) d1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(1'b0),
    .busy(s1_busy), .done(s1_done), .rd_en(s1_rd_en),
    .rd_addr(s1_addr), .rd_data(s1_rdata), .out_valid(s1_valid),
    .out_ready(1'b1), .out_data(s1_data), .out_index(s1_idx)
  );

  reg_dump_reader #(.NUM_REGS(20)) d20 (
    .clk(clk), .rst(rst), .start(s20_start), .abort(1'b0),
    .busy(s20_busy), .done(s20_done), .rd_en(s20_rd_en),
    .rd_addr(s20_addr), .rd_data(s20_rdata), .out_valid(s20_valid),
    .out_ready(1'b1), .out_data(s20_data), .out_index(s20_idx)
  );

  // bank models: reg[i] = A5A5_0000 + i, one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= 32'hA5A5_0000 + 32'(rd_addr);
    if (s1_rd_en) s1_rdata <= 32'hA5A5_0000 + 32'(s1_addr);
    if (s20_rd_en) s20_rdata <= 32'hA5A5_0000 + 32'(s20_addr);
  end

  int          qi[$];
  logic [31:0] qd[$];
  int          qc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          q1[$];
  int          q20[$];
  logic [31:0] q20d[$];
  int          d1_cnt = 0;
  int          d20_cnt = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      qi.push_back(int'(out_index));
      qd.push_back(out_data);
      qc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s1_valid) q1.push_back(int'(s1_idx));
    if (s1_done) d1_cnt++;
    if (s20_valid) begin
      q20.push_back(int'(s20_idx));
      q20d.push_back(s20_data);
    end
    if (s20_done) d20_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic take_beat(input int ei, input int stall);
    wait_valid();
    chk("beat_idx", out_index, ei);
    chk("beat_data", out_data, 32'hA5A5_0000 + ei);
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 32'hA5A5_0000 + ei);
      chk("stall_idx", out_index, ei);
      chk("stall_rd_en", rd_en, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic full_dump(input string tag);
    int n;
    qi.delete();
    qd.delete();
    qc.delete();
    done_cnt = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_lat_rd_en"}, rd_en, 1);
    chk({tag, "_lat_busy"}, busy, 1);
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat_valid"}, n, 3);
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_beats"}, qi.size(), 32);
    for (int i = 0; i < qi.size(); i++) begin
      chk({tag, "_idx"}, qi[i], i);
      chk({tag, "_data"}, qd[i], 32'hA5A5_0000 + i);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (qc.size() == 32) begin
      chk({tag, "_done_lag"}, done_cyc - qc[31], 1);
      chk({tag, "_span"}, qc[31] - qc[0], 93);
    end
    chk({tag, "_busy_end"}, busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    // 1: reset with random inputs
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom);
      abort = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rst_outs", {busy, done, rd_en, rd_addr, out_valid,
                       out_data, out_index}, 0);
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", rd_en, 0);

    // 2: full dump with ready held high
    full_dump("dump1");

    // 3+4: stall at 7, ignored start, abort at 10
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      take_beat(i, (i == 7) ? 5 : 0);
      if (i == 8) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_valid();
    chk("pre_abort_idx", out_index, 10);
    dc = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_keep_idx", out_index, 10);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    chk("abort_no_rd", rd_en, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    take_beat(0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);

    // 5: reset during PRESENT, then a clean dump
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, rd_en, rd_addr, out_valid,
                        out_index}, 0);
    chk("midrst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    full_dump("dump2");

    // 6: short banks
    q1.delete();
    q20.delete();
    q20d.delete();
    d1_cnt = 0;
    d20_cnt = 0;
    s1_start = 1'b1;
    s20_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    s20_start = 1'b0;
    repeat (80) @(negedge clk);
    chk("n1_beats", q1.size(), 1);
    if (q1.size() > 0) chk("n1_idx", q1[0], 0);
    chk("n1_done", d1_cnt, 1);
    chk("n20_beats", q20.size(), 20);
    for (int i = 0; i < q20.size(); i++)
      chk("n20_idx", q20[i], i);
    if (q20d.size() == 20) chk("n20_last", q20d[19], 32'hA5A5_0013);
    chk("n20_done", d20_cnt, 1);
    chk("n20_busy", s20_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
